ctrl_pipe: RTL and testbench

- Receiving end of the main control decoder's outputs in the 5-stage pipelined MIPS core.
- Registers the decoded control bundle and register-number fields through the ID/EX, EX/MEM and MEM/WB stages.
- Inserts bubbles on load-use stalls and on taken-branch flushes.
- Produces the stall and forwarding-select signals consumed by the PC/IF-ID logic and the EX operand muxes.

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/hazard_fwd_unit.sv | 55 +++++
 rtl/ctrl_pipe.sv | 110 +++++++++++
 tb/tb_ctrl_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the MIPS control pipeline: stage bundles,
// aluop encodings, forwarding selects and the all-zero bubble bundles.
package ctrl_pkg;

  localparam int REG_W = 5;
  localparam int AOP_W = 2;

  localparam logic [AOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [AOP_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [AOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [AOP_W-1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic             regdst;
    logic             alusrc;
    logic [AOP_W-1:0] aluop;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             beq;
    logic             bne;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             beq;
    logic             bne;
    logic [REG_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic [REG_W-1:0] dst;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // A later stage wins over an older one; register 0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             mem_we,
    input logic [REG_W-1:0] mem_dst,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_dst
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_we && (mem_dst != '0) && (mem_dst == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational stall and EX operand forwarding selects.
// CTRL_PIPE_FWD_EN: defined = forward and stall on load-use only; undefined = no forwarding, stall on any RAW.
module hazard_fwd_unit
  import ctrl_pkg::*;
(
  input  logic             flush_i,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             idex_memread,
  input  logic             idex_regwrite,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_dst,
  output logic             stall_o,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

`ifdef CTRL_PIPE_FWD_EN
  logic load_use;
  logic unused_ok;

  always_comb begin
    load_use = idex_memread && (idex_rt != '0) &&
               ((idex_rt == id_rs) || (idex_rt == id_rt));
    fwd_a    = fwd_sel(idex_rs, exmem_regwrite, mem_dst, wb_regwrite, wb_dst);
    fwd_b    = fwd_sel(idex_rt, exmem_regwrite, mem_dst, wb_regwrite, wb_dst);
  end

  assign stall_o   = load_use && !flush_i;
  assign unused_ok = ^{idex_regwrite, ex_dst};
`else
  logic ex_hit;
  logic mem_hit;
  logic unused_ok;

  // The register file writes early in the cycle, so MEM/WB never needs a stall.
  always_comb begin
    ex_hit  = idex_regwrite && (ex_dst != '0) &&
              ((ex_dst == id_rs) || (ex_dst == id_rt));
    mem_hit = exmem_regwrite && (mem_dst != '0) &&
              ((mem_dst == id_rs) || (mem_dst == id_rt));
    fwd_a   = FWD_REG;
    fwd_b   = FWD_REG;
  end

  assign stall_o   = (ex_hit || mem_hit) && !flush_i;
  assign unused_ok = ^{idex_memread, idex_rs, idex_rt, wb_regwrite, wb_dst};
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with bubble insertion on stall/flush.
// Optional forwarding is selected by CTRL_PIPE_FWD_EN (see hazard_fwd_unit).
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_regdst,
  input  logic             id_alusrc,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [AOP_W-1:0] id_aluop,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic [AOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_beq,
  output logic             mem_bne,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] mem_dst,
  output logic [REG_W-1:0] wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [REG_W-1:0] ex_dst;

  assign ex_dst = idex_q.regdst ? idex_q.rd : idex_q.rt;

  hazard_fwd_unit u_hazard (
    .flush_i        (flush_i),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .idex_memread   (idex_q.memread),
    .idex_regwrite  (idex_q.regwrite),
    .idex_rs        (idex_q.rs),
    .idex_rt        (idex_q.rt),
    .ex_dst         (ex_dst),
    .exmem_regwrite (exmem_q.regwrite),
    .mem_dst        (exmem_q.dst),
    .wb_regwrite    (memwb_q.regwrite),
    .wb_dst         (memwb_q.dst),
    .stall_o        (stall_o),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  always_comb begin
    idex_d = '{regdst: id_regdst, alusrc: id_alusrc, aluop: id_aluop,
               memread: id_memread, memwrite: id_memwrite, memtoreg: id_memtoreg,
               regwrite: id_regwrite, beq: id_beq, bne: id_bne,
               rs: id_rs, rt: id_rt, rd: id_rd};
    // Dropping regwrite for a $zero destination keeps it out of forwarding and WB.
    exmem_d = '{memread: idex_q.memread, memwrite: idex_q.memwrite,
                memtoreg: idex_q.memtoreg,
                regwrite: idex_q.regwrite && (ex_dst != '0),
                beq: idex_q.beq, bne: idex_q.bne, dst: ex_dst};
    memwb_d = '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg,
                dst: exmem_q.dst};
    if (flush_i) begin
      idex_d  = IDEX_BUBBLE;
      exmem_d = EXMEM_BUBBLE;
    end else if (stall_o) begin
      idex_d  = IDEX_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= EXMEM_BUBBLE;
      memwb_q <= MEMWB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_regdst    = idex_q.regdst;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_aluop     = idex_q.aluop;
  assign ex_rs        = idex_q.rs;
  assign ex_rt        = idex_q.rt;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign mem_beq      = exmem_q.beq;
  assign mem_bne      = exmem_q.bne;
  assign mem_dst      = exmem_q.dst;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_dst       = memwb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: instruction records flow through a three-slot model
// (EX, MEM, WB); outputs and hazard signals are derived from those records.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       beq;
    logic       bne;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ins_t;

  typedef struct {
    ins_t     ins;
    bit       fl;
    bit       s_f;
    bit [1:0] fa_f;
    bit [1:0] fb_f;
    bit       s_n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_regdst = 0, id_alusrc = 0, id_memread = 0, id_memwrite = 0;
  logic       id_memtoreg = 0, id_regwrite = 0, id_beq = 0, id_bne = 0;
  logic [1:0] id_aluop = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       flush_i = 1'b0;
  logic       stall_o, ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rs, ex_rt;
  logic       mem_memread, mem_memwrite, mem_beq, mem_bne;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] mem_dst, wb_dst;
  logic [1:0] fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  ins_t st[3];
  vec_t tbl[13];

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_beq(id_beq), .id_bne(id_bne), .id_aluop(id_aluop),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush_i(flush_i),
    .stall_o(stall_o), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_beq(mem_beq), .mem_bne(mem_bne), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .mem_dst(mem_dst), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // ---------------- instruction constructors ----------------
  function automatic ins_t r_ins(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.regdst = 1'b1; i.regwrite = 1'b1; i.aluop = 2'b10;
    i.rd = rd; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic ins_t lw_ins(input logic [4:0] rt, input logic [4:0] rs);
    ins_t i = '0;
    i.alusrc = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1;
    i.rt = rt; i.rs = rs;
    return i;
  endfunction

  function automatic ins_t sw_ins(input logic [4:0] rt, input logic [4:0] rs);
    ins_t i = '0;
    i.alusrc = 1'b1; i.memwrite = 1'b1; i.rt = rt; i.rs = rs;
    return i;
  endfunction

  function automatic ins_t beq_ins(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.beq = 1'b1; i.aluop = 2'b01; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic logic [4:0] pick_reg();
    int r = $urandom_range(0, 3);
    return (r == 0) ? 5'd0 : 5'(7 + r);
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.regdst = 1'($urandom_range(0, 1)); i.alusrc = 1'($urandom_range(0, 1));
    i.aluop = 2'($urandom_range(0, 3)); i.memread = 1'($urandom_range(0, 1));
    i.memwrite = 1'($urandom_range(0, 1)); i.memtoreg = 1'($urandom_range(0, 1));
    i.regwrite = 1'($urandom_range(0, 1)); i.beq = 1'($urandom_range(0, 1));
    i.bne = 1'($urandom_range(0, 1));
    i.rs = pick_reg(); i.rt = pick_reg(); i.rd = pick_reg();
    return i;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [4:0] dst_of(input ins_t i);
    return i.regdst ? i.rd : i.rt;
  endfunction

  function automatic bit writes(input ins_t i);
    return i.regwrite && (dst_of(i) != 5'd0);
  endfunction

  function automatic bit model_stall(input ins_t id, input bit fl);
    bit s = 1'b0;
`ifdef CTRL_PIPE_FWD_EN
    s = st[0].memread && (st[0].rt != 5'd0) && (st[0].rt == id.rs || st[0].rt == id.rt);
`else
    for (int k = 0; k < 2; k++)
      if (writes(st[k]) && (dst_of(st[k]) == id.rs || dst_of(st[k]) == id.rt)) s = 1'b1;
`endif
    return s && !fl;
  endfunction

  function automatic bit [1:0] model_fwd(input logic [4:0] src);
`ifdef CTRL_PIPE_FWD_EN
    if (writes(st[1]) && dst_of(st[1]) == src) return 2'b10;
    if (writes(st[2]) && dst_of(st[2]) == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: present ID inputs, compare every output, advance the model, wait.
  task automatic drive(input ins_t i, input bit fl, input bit rn,
                       output bit ds, output bit [1:0] dfa, output bit [1:0] dfb, output bit ms);
    ins_t z = '0;
    {id_regdst, id_alusrc, id_aluop, id_memread, id_memwrite, id_memtoreg,
     id_regwrite, id_beq, id_bne, id_rs, id_rt, id_rd} = i;
    flush_i = fl;
    rst_n   = rn;
    #1;
    ms = model_stall(i, fl);
    chk("stall", 8'(stall_o), 8'(ms));
    chk("fwd_a", 8'(fwd_a), 8'(model_fwd(st[0].rs)));
    chk("fwd_b", 8'(fwd_b), 8'(model_fwd(st[0].rt)));
    chk("ex_ctrl", 8'({ex_regdst, ex_alusrc, ex_aluop}), 8'({st[0].regdst, st[0].alusrc, st[0].aluop}));
    chk("ex_rs", 8'(ex_rs), 8'(st[0].rs));
    chk("ex_rt", 8'(ex_rt), 8'(st[0].rt));
    chk("mem_ctrl", 8'({mem_memread, mem_memwrite, mem_beq, mem_bne}),
        8'({st[1].memread, st[1].memwrite, st[1].beq, st[1].bne}));
    chk("mem_dst", 8'(mem_dst), 8'(dst_of(st[1])));
    chk("wb_ctrl", 8'({wb_regwrite, wb_memtoreg}), 8'({writes(st[2]), st[2].memtoreg}));
    chk("wb_dst", 8'(wb_dst), 8'(dst_of(st[2])));
    ds = stall_o; dfa = fwd_a; dfb = fwd_b;
    if (!rn) begin
      st[0] = z; st[1] = z; st[2] = z;
    end else if (fl) begin
      st[2] = st[1]; st[1] = z; st[0] = z;
    end else begin
      st[2] = st[1]; st[1] = st[0]; st[0] = ms ? z : i;
    end
    @(negedge clk);
  endtask

  // Re-present an instruction while the model says IF/ID is held.
  task automatic issue(input ins_t i, output bit [1:0] fa0, output bit [1:0] fb0, output int ns);
    bit d, m;
    bit [1:0] a, b;
    ns = 0; fa0 = '0; fb0 = '0;
    for (int t = 0; t < 6; t++) begin
      drive(i, 1'b0, 1'b1, d, a, b, m);
      if (t == 0) begin fa0 = a; fb0 = b; end
      if (d) ns++;
      if (!m) break;
    end
  endtask

  task automatic drain();
    bit d, m;
    bit [1:0] a, b;
    for (int t = 0; t < 3; t++) drive('0, 1'b0, 1'b1, d, a, b, m);
  endtask

  bit       ds, ms;
  bit [1:0] fa0, fb0;
  int       ns;
  bit       es;
  bit [1:0] efa, efb;

  initial begin
    for (int k = 0; k < 3; k++) st[k] = '0;

    tbl[0]  = '{r_ins(8, 9, 10),   1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{r_ins(9, 8, 10),   1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[2]  = '{r_ins(9, 8, 10),   1'b0, 1'b0, 2'b10, 2'b00, 1'b1};
    tbl[3]  = '{r_ins(9, 8, 10),   1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[4]  = '{sw_ins(9, 11),     1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{sw_ins(9, 11),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[6]  = '{beq_ins(8, 11),    1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{ins_t'('0),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{lw_ins(8, 11),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[9]  = '{r_ins(11, 8, 8),   1'b0, 1'b1, 2'b00, 2'b00, 1'b1};
    tbl[10] = '{r_ins(11, 8, 8),   1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[11] = '{ins_t'('0),        1'b0, 1'b0, 2'b01, 2'b01, 1'b0};
    tbl[12] = '{ins_t'('0),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

    @(negedge clk);

    // Reset held for two cycles with random ID inputs and flushes.
    for (int c = 0; c < 2; c++)
      drive(rand_ins(), 1'($urandom_range(0, 1)), 1'b0, ds, fa0, fb0, ms);

    // Table-driven sequence: stall and forwarding expected per row.
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].ins, tbl[k].fl, 1'b1, ds, fa0, fb0, ms);
`ifdef CTRL_PIPE_FWD_EN
      es = tbl[k].s_f; efa = tbl[k].fa_f; efb = tbl[k].fb_f;
`else
      es = tbl[k].s_n; efa = 2'b00; efb = 2'b00;
`endif
      $display("vec %0d: stall=%0b fwd_a=%0b fwd_b=%0b", k, ds, fa0, fb0);
      chk($sformatf("tbl%0d_stall", k), 8'(ds), 8'(es));
      chk($sformatf("tbl%0d_fwd_a", k), 8'(fa0), 8'(efa));
      chk($sformatf("tbl%0d_fwd_b", k), 8'(fb0), 8'(efb));
    end

    // lw $t0 then add $t1,$t0,$t2: stall, bubble in EX, then forward from WB.
    drain();
    drive(lw_ins(8, 10), 1'b0, 1'b1, ds, fa0, fb0, ms);
    ns = 0;
    for (int t = 0; t < 4; t++) begin
      drive(r_ins(9, 8, 10), 1'b0, 1'b1, ds, fa0, fb0, ms);
      if (ds) ns++;
      if (t == 0) begin
        chk("lu_bubble_ctrl", 8'({ex_regdst, ex_alusrc, ex_aluop}), 8'd0);
        chk("lu_bubble_regs", 8'({ex_rs, ex_rt}), 8'd0);
      end
      if (!ms) break;
    end
`ifdef CTRL_PIPE_FWD_EN
    chk("lu_stall_cycles", 8'(ns), 8'd1);
`else
    chk("lu_stall_cycles", 8'(ns), 8'd2);
`endif
    drive('0, 1'b0, 1'b1, ds, fa0, fb0, ms);
`ifdef CTRL_PIPE_FWD_EN
    chk("lu_fwd_a", 8'(fa0), 8'h01);
`else
    chk("lu_fwd_a", 8'(fa0), 8'h00);
`endif
    $display("seq load-use: stall_cycles=%0d fwd_a=%0b", ns, fa0);

    // add $t0; sub $t3,$t0,$t0; sub $t4,$t0,$t0.
    drain();
    issue(r_ins(8, 9, 10), fa0, fb0, ns);
    issue(r_ins(11, 8, 8), fa0, fb0, ns);
`ifdef CTRL_PIPE_FWD_EN
    chk("raw_stall_cycles", 8'(ns), 8'd0);
`else
    chk("raw_stall_cycles", 8'(ns), 8'd2);
`endif
    issue(r_ins(12, 8, 8), fa0, fb0, ns);
`ifdef CTRL_PIPE_FWD_EN
    chk("raw_exmem_fwd", 8'({fa0, fb0}), 8'b1010);
`else
    chk("raw_exmem_fwd", 8'({fa0, fb0}), 8'b0000);
`endif
    drive('0, 1'b0, 1'b1, ds, fa0, fb0, ms);
`ifdef CTRL_PIPE_FWD_EN
    chk("raw_memwb_fwd", 8'({fa0, fb0}), 8'b0101);
`else
    chk("raw_memwb_fwd", 8'({fa0, fb0}), 8'b0000);
`endif
    $display("seq raw: second-sub fwd_a=%0b fwd_b=%0b", fa0, fb0);

    // Flush with sw in EX and beq in MEM.
    drain();
    issue(beq_ins(8, 11), fa0, fb0, ns);
    issue(sw_ins(9, 11), fa0, fb0, ns);
    drive('0, 1'b1, 1'b1, ds, fa0, fb0, ms);
    chk("fl_mem_memwrite", 8'(mem_memwrite), 8'd0);
    chk("fl_mem_beq", 8'(mem_beq), 8'd0);
    chk("fl_ex_ctrl", 8'({ex_regdst, ex_alusrc, ex_aluop}), 8'd0);
    chk("fl_wb_regwrite", 8'(wb_regwrite), 8'd0);
    chk("fl_wb_dst", 8'(wb_dst), 8'd11);
    $display("seq flush: mem_memwrite=%0b wb_dst=%0d", mem_memwrite, wb_dst);

    // R-type writing $zero, followed by a reader of $zero.
    drain();
    issue(r_ins(0, 9, 9), fa0, fb0, ns);
    issue(r_ins(10, 0, 0), fa0, fb0, ns);
    chk("z_mem_dst", 8'(mem_dst), 8'd0);
    drive('0, 1'b0, 1'b1, ds, fa0, fb0, ms);
    chk("z_fwd", 8'({fa0, fb0}), 8'd0);
    chk("z_wb_regwrite", 8'(wb_regwrite), 8'd0);
    $display("seq zero-dst: fwd=%0b%0b wb_regwrite=%0b", fa0, fb0, wb_regwrite);

    // Random traffic with occasional flushes and mid-stream resets.
    for (int c = 0; c < 400; c++)
      drive(rand_ins(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0),
            ds, fa0, fb0, ms);
    $display("random phase: 400 cycles applied");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
